// File: rtl/FixedPoint.sv
// Signed 16.16 fixed-point type and saturating arithmetic shared across the datapath.
package FixedPoint;

  typedef logic signed [31:0] sfp;

  localparam sfp ONE     = 32'sh0001_0000;
  localparam sfp SFP_MAX = 32'sh7FFF_FFFF;
  localparam sfp SFP_MIN = 32'sh8000_0000;

  function automatic sfp sfp_add(input sfp a, input sfp b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
    return s[31:0];
  endfunction

  function automatic sfp sfp_sub(input sfp a, input sfp b);
    logic signed [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
    return s[31:0];
  endfunction

  // Product is truncated toward -inf after dropping the 16 extra fraction bits.
  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [63:0] p;
    p = a * b;
    p = p >>> 16;
    if (p[63:31] != {33{p[31]}}) return p[63] ? SFP_MIN : SFP_MAX;
    return p[31:0];
  endfunction

endpackage

// File: rtl/output_error_unit_pkg.sv
// Shared types for the output error unit.
package output_error_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    TRAIN  = 2'd2,
    REPORT = 2'd3
  } err_state_t;

endpackage

// File: rtl/squared_error_lane.sv
// Single-lane error term: diff = pred - tgt and its saturated square.
module squared_error_lane
  import FixedPoint::*;
(
  input  logic [31:0] pred,
  input  logic [31:0] tgt,
  output logic [31:0] diff,
  output logic [31:0] diff_sq
);

  sfp diff_s;

  assign diff_s  = sfp_sub(sfp'(pred), sfp'(tgt));
  assign diff    = diff_s;
  assign diff_sq = sfp_mul(diff_s, diff_s);

endmodule

// File: rtl/output_error_unit.sv
// Output-layer error stage: serial dL/dy per lane, training strobe, batched squared-error loss.
module output_error_unit
  import FixedPoint::*;
  import output_error_unit_pkg::*;
#(
  parameter int OUTPUT_UNITS = 2,
  parameter int BATCH_LEN    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OUTPUT_UNITS-1:0][31:0] predictions,
  input  logic [OUTPUT_UNITS-1:0][31:0] targets,
  input  logic                         train_en,
  output logic [OUTPUT_UNITS-1:0][31:0] error_gradient,
  output logic [OUTPUT_UNITS-1:0][31:0] next_layer_weights,
  output logic                         training,
  output logic [31:0]                  loss,
  output logic                         loss_valid,
  output logic                         busy
);

  localparam int IDX_W = (OUTPUT_UNITS > 1) ? $clog2(OUTPUT_UNITS) : 1;
  localparam int CNT_W = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;

  err_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        sample_cnt;
  sfp                      acc;
  sfp [OUTPUT_UNITS-1:0]   pred_q;
  sfp [OUTPUT_UNITS-1:0]   tgt_q;
  sfp [OUTPUT_UNITS-1:0]   grad_shadow;
  sfp [OUTPUT_UNITS-1:0]   grad_next;
  logic [31:0]             lane_diff;
  logic [31:0]             lane_sq;

  squared_error_lane u_lane (
    .pred    (pred_q[idx]),
    .tgt     (tgt_q[idx]),
    .diff    (lane_diff),
    .diff_sq (lane_sq)
  );

  // Last lane's diff lands in the shadow on the same edge it is published.
  always_comb begin
    grad_next      = grad_shadow;
    grad_next[idx] = sfp'(lane_diff);
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE) && !rst;
  assign training = (state == TRAIN) && train_en && !rst;

  always_comb begin
    for (int i = 0; i < OUTPUT_UNITS; i++) next_layer_weights[i] = ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      sample_cnt     <= '0;
      acc            <= '0;
      error_gradient <= '0;
      loss           <= '0;
      loss_valid     <= 1'b0;
    end else begin
      loss_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= sfp_add(acc, sfp'(lane_sq));
          if (idx == IDX_W'(OUTPUT_UNITS - 1)) begin
            error_gradient <= grad_next;
            state          <= TRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        TRAIN: begin
          if (sample_cnt == CNT_W'(BATCH_LEN - 1)) begin
            sample_cnt <= '0;
            state      <= REPORT;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            state      <= IDLE;
          end
        end
        REPORT: begin
          loss       <= acc;
          loss_valid <= 1'b1;
          acc        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample capture and per-lane shadow carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      pred_q <= predictions;
      tgt_q  <= targets;
    end
    if (state == CALC) grad_shadow <= grad_next;
  end

endmodule

// File: tb/tb_output_error_unit.sv
// Directed bench for output_error_unit (OUTPUT_UNITS=2, BATCH_LEN=4).
module tb_output_error_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0][31:0]  predictions;
  logic [1:0][31:0]  targets;
  logic              train_en;
  logic [1:0][31:0]  error_gradient;
  logic [1:0][31:0]  next_layer_weights;
  logic              training;
  logic [31:0]       loss;
  logic              loss_valid;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  output_error_unit #(.OUTPUT_UNITS(2), .BATCH_LEN(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .predictions        (predictions),
    .targets            (targets),
    .train_en           (train_en),
    .error_gradient     (error_gradient),
    .next_layer_weights (next_layer_weights),
    .training           (training),
    .loss               (loss),
    .loss_valid         (loss_valid),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample end to end: handshake, two CALC cycles, TRAIN, optional REPORT.
  task automatic do_sample(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] t0, input logic [31:0] t1,
                           input logic ten, input logic [31:0] e0, input logic [31:0] e1,
                           input logic last, input logic [31:0] exp_loss);
    int k;
    predictions[0] = p0; predictions[1] = p1;
    targets[0]     = t0; targets[1]     = t1;
    train_en = ten;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("calc1_ready", 32'(in_ready), 32'd0);
    chk("calc1_busy", 32'(busy), 32'd1);
    tick();
    chk("calc2_ready", 32'(in_ready), 32'd0);
    chk("calc2_training", 32'(training), 32'd0);
    tick();
    chk("train_strobe", 32'(training), 32'(ten));
    chk("train_ready", 32'(in_ready), 32'd0);
    chk("grad0", error_gradient[0], e0);
    chk("grad1", error_gradient[1], e1);
    tick();
    chk("strobe_end", 32'(training), 32'd0);
    if (last) begin
      chk("report_ready", 32'(in_ready), 32'd0);
      tick();
      chk("loss_valid", 32'(loss_valid), 32'd1);
      chk("loss", loss, exp_loss);
      tick();
      chk("loss_valid_end", 32'(loss_valid), 32'd0);
      chk("loss_hold", loss, exp_loss);
    end else begin
      chk("back_ready", 32'(in_ready), 32'd1);
      chk("no_loss_valid", 32'(loss_valid), 32'd0);
    end
  endtask

  logic [31:0] acc_val [8];
  int          n_acc;
  int          n_tr;
  int          kk;
  longint      exp5;

  initial begin
    rst = 1'b1; in_valid = 1'b0; train_en = 1'b1;
    predictions = '0; targets = '0;

    // Reset state
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_training", 32'(training), 32'd0);
    chk("rst_loss", loss, 32'd0);
    chk("rst_loss_valid", 32'(loss_valid), 32'd0);
    chk("rst_grad0", error_gradient[0], 32'd0);
    chk("rst_weight0", next_layer_weights[0], 32'h0001_0000);
    chk("rst_weight1", next_layer_weights[1], 32'h0001_0000);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Scenarios 1 and 2: pred {0.75,0.25} vs tgt {1.0,0.0}, two full batches
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++)
        do_sample(32'h0000_C000, 32'h0000_4000, 32'h0001_0000, 32'h0,
                  1'b1, 32'hFFFF_C000, 32'h0000_4000, s == 3, 32'h0000_8000);
    end

    // Scenario 3: training suppressed; pred {0.5,-0.5}, tgt 0 -> batch loss 2.0
    for (int s = 0; s < 4; s++)
      do_sample(32'h0000_8000, 32'hFFFF_8000, 32'h0, 32'h0,
                1'b0, 32'h0000_8000, 32'hFFFF_8000, s == 3, 32'h0002_0000);

    // Scenario 4: two samples, then reset during CALC of the third
    for (int s = 0; s < 2; s++)
      do_sample(32'h0001_0000, 32'h0, 32'h0, 32'h0,
                1'b1, 32'h0001_0000, 32'h0, 1'b0, 32'h0);
    train_en = 1'b1;
    in_valid = 1'b1;
    chk("s4_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("s4_calc_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("s4_rst_ready", 32'(in_ready), 32'd0);
    chk("s4_rst_busy", 32'(busy), 32'd0);
    tick();
    chk("s4_grad0", error_gradient[0], 32'd0);
    chk("s4_grad1", error_gradient[1], 32'd0);
    chk("s4_loss", loss, 32'd0);
    chk("s4_loss_valid", 32'(loss_valid), 32'd0);
    chk("s4_training", 32'(training), 32'd0);
    chk("s4_weight1", next_layer_weights[1], 32'h0001_0000);
    rst = 1'b0;
    tick();
    chk("s4_ready_after", 32'(in_ready), 32'd1);
    // pred {1.0,0.5}: 1.25 per sample, 5.0 per batch
    for (int s = 0; s < 4; s++)
      do_sample(32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0,
                1'b1, 32'h0001_0000, 32'h0000_8000, s == 3, 32'h0005_0000);

    // Scenario 5: in_valid held high with data changing every cycle
    n_acc = 0; n_tr = 0; kk = 0; exp5 = 0;
    targets = '0; predictions = '0; train_en = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && n_tr < 4; c++) begin
      predictions[0] = 32'((kk + 1) * 4096);
      kk++;
      if (in_ready && n_acc < 8) begin
        acc_val[n_acc] = predictions[0];
        n_acc++;
      end
      tick();
      if (training && n_tr < 8) begin
        chk("s5_grad", error_gradient[0], acc_val[n_tr]);
        n_tr++;
      end
    end
    in_valid = 1'b0;
    chk("s5_trainings", 32'(n_tr), 32'd4);
    chk("s5_acceptances", 32'(n_acc), 32'd4);
    for (int i = 0; i < 4 && i < n_acc; i++)
      exp5 += (longint'(acc_val[i]) * longint'(acc_val[i])) >>> 16;
    tick();
    tick();
    chk("s5_loss_valid", 32'(loss_valid), 32'd1);
    chk("s5_loss", loss, 32'(exp5));

    // Scenario 6: saturating diff and accumulator
    for (int s = 0; s < 4; s++)
      do_sample(32'h7FFF_0000, 32'h7FFF_0000, 32'h8001_0000, 32'h8001_0000,
                1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, s == 3, 32'h7FFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/output_error_unit.md
Name: output_error_unit

Overview:
- Sits at the tail end of the backpropagation chain, downstream of the output-layer perceptrons.
- Consumes each sample's predictions and targets over a valid/ready handshake.
- Computes dL/dy = prediction - target per output serially, presents the vector plus unity weights to the output layer, and issues a one-cycle training strobe.
- Accumulates squared error over BATCH_LEN samples and reports it with a one-cycle loss_valid pulse.

Parameters:
- OUTPUT_UNITS, 2, number of output-layer perceptrons (>=1).
- BATCH_LEN, 4, samples per loss report (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  predictions/targets valid
- in_ready  out  1  unit can accept a sample
- predictions  in  sfp[OUTPUT_UNITS]  output-layer perceptron predictions
- targets  in  sfp[OUTPUT_UNITS]  expected values
- train_en  in  1  when 0, compute and accumulate loss but suppress training strobe
- error_gradient  out  sfp[OUTPUT_UNITS]  dL/dy per output, fed to error_gradient_next_layer
- next_layer_weights  out  sfp[OUTPUT_UNITS]  constant ONE per lane
- training  out  1  one-cycle weight-update strobe
- loss  out  sfp  batch sum of squared error, valid with loss_valid
- loss_valid  out  1  one-cycle pulse at batch end
- busy  out  1  state != IDLE

Behaviour:
- sfp is 32-bit signed fixed point with 16 fractional bits (ONE = 0x0001_0000). All arithmetic uses FixedPoint sfp_add, sfp_sub and sfp_mul, which saturate.
- FSM states: IDLE, CALC, TRAIN, REPORT.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch predictions and targets, idx<=0, go to CALC.
  - in_valid without in_ready is ignored. The upstream block must hold data until accepted.
- CALC: one lane per cycle.
  - diff = sfp_sub(pred[idx], tgt[idx]); grad_shadow[idx] <= diff.
  - acc <= sfp_add(acc, sfp_mul(diff, diff)).
  - idx increments. After idx == OUTPUT_UNITS-1, copy the shadow to error_gradient and go to TRAIN.
- TRAIN: training = train_en for exactly this cycle; error_gradient is stable here.
  - If sample_cnt == BATCH_LEN-1: sample_cnt<=0, go to REPORT.
  - Else: sample_cnt++, go to IDLE.
- REPORT: loss <= acc, loss_valid=1 for one cycle, acc<=0, go to IDLE.
- Latency (acceptance in cycle 0):
  - CALC occupies cycles 1..OUTPUT_UNITS.
  - TRAIN is cycle OUTPUT_UNITS+1.
  - REPORT, if taken, is the next cycle.
  - in_ready returns the cycle after the last of these.
  - Sustained throughput is one sample per OUTPUT_UNITS+2 cycles (+1 cycle at batch end).
- Outputs hold their last values between updates. loss holds until the next REPORT.
- next_layer_weights is always ONE per lane, including during reset.
- Reset, and any cycle rst is high (mid-operation included):
  - state=IDLE, in_ready=0 during the rst cycle then 1.
  - error_gradient=0, training=0, loss=0, loss_valid=0, busy=0.
  - acc=0, sample_cnt=0, idx=0; the in-flight sample is discarded.
- Accumulator saturates at max sfp, never wraps. A saturated value is reported as-is.
- train_en is sampled only in TRAIN. Changing it mid-sample affects only that strobe.
- BATCH_LEN=1: every sample goes through REPORT.

Decomposition:
- Common package:
  - typedef enum err_state_t {IDLE, CALC, TRAIN, REPORT}.
  - localparam SFP_MAX for saturation checks, if not already in FixedPoint.
- FixedPoint package: reuse the existing sfp, ONE, sfp_add, sfp_sub and sfp_mul.
- Sub-module squared_error_lane (combinational): takes pred and tgt, returns diff and diff². It is instantiated once and muxed by idx.

Test Plan:
1. Reset, then OUTPUT_UNITS=2: pred={0.75, 0.25}, tgt={1.0, 0.0}, train_en=1 -> after 3 cycles, error_gradient={0xFFFF_C000, 0x0000_4000}, training high for exactly 1 cycle, in_ready low during cycles 1-3.
2. BATCH_LEN=4, the sample from scenario 1 repeated 4 times -> a single loss_valid pulse with loss = 8×0.0625 = 0x0000_8000, acc cleared, and the next batch's report is identical.
3. train_en=0 for a full batch -> training never asserts, while error_gradient and the loss report still update normally.
4. Assert rst during CALC of the third sample -> all outputs return to their reset values; the next batch's loss excludes the pre-reset samples (sample_cnt restarts at 0).
5. in_valid held high continuously with changing data -> exactly one acceptance per in_ready window, no sample is lost or duplicated, and the latched data matches the value present at the handshake.
6. pred=0x7FFF_0000, tgt=0x8001_0000 -> diff saturates to max sfp, acc saturates and does not wrap, and loss = SFP_MAX.
